// File: rtl/audio_pwm_out.sv
// ---------------------------------------------------------------------------
// audio_pwm_out
//
// Audio output stage. Signed PCM samples arrive over a valid/ready handshake
// into a one-entry holding buffer. At the last cycle of every PWM frame the
// buffered sample is scaled by the current 4-bit volume, offset to midscale
// and loaded as the new PWM duty. Two debounced buttons step the volume.
//
// Ports
//   clk            system clock
//   resetn         asynchronous active-low reset
//   en             output enable (play)
//   sample_in      signed two's-complement sample
//   sample_valid   sample_in valid this cycle
//   sample_ready   holding buffer empty, a sample can be accepted
//   vol_up         raw volume-up button
//   vol_down       raw volume-down button
//   aud_pwm        PWM audio output
//   aud_sd         amplifier enable (1 = on)
//   volume_monitor current volume
//   frame_tick     one-cycle pulse on the last cycle of each PWM frame
//   underrun       one-cycle pulse after a frame boundary with an empty buffer
// ---------------------------------------------------------------------------

// Button conditioner: 2-FF synchronizer, hold-time debounce, and a one-cycle
// step pulse on each accepted press (debounced rising edge).
module audio_pwm_debounce #(
  parameter int CYCLES = 1000000
) (
  input  logic clk,
  input  logic resetn,
  input  logic raw,
  output logic step
);
  localparam int CW = $clog2(CYCLES + 1);
  localparam logic [CW-1:0] COUNT_LAST = CW'(CYCLES - 1);

  logic [1:0]    sync;
  logic          level;
  logic [CW-1:0] count;
  logic          synced;

  assign synced = sync[1];

  // NOTE: sequential state is only ever assigned with <= so every register
  // samples the values from before the edge, independent of statement order.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sync  <= '0;
      level <= 1'b0;
      count <= '0;
      step  <= 1'b0;
    end else begin
      sync <= {sync[0], raw};
      step <= 1'b0;
      if (synced == level) begin
        // Any sample agreeing with the accepted level restarts the hold time.
        count <= '0;
      end else if (count == COUNT_LAST) begin
        level <= synced;
        count <= '0;
        step  <= synced;
      end else begin
        count <= count + 1'b1;
      end
    end
  end
endmodule

module audio_pwm_out #(
  parameter int SAMPLE_W        = 12,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int VOL_RESET       = 8
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                en,
  input  logic [SAMPLE_W-1:0] sample_in,
  input  logic                sample_valid,
  output logic                sample_ready,
  input  logic                vol_up,
  input  logic                vol_down,
  output logic                aud_pwm,
  output logic                aud_sd,
  output logic [3:0]          volume_monitor,
  output logic                frame_tick,
  output logic                underrun
);
  localparam int PW = SAMPLE_W + 5;
  localparam logic [SAMPLE_W-1:0] CNT_LAST = '1;
  localparam logic [SAMPLE_W-1:0] CNT_PRE  = CNT_LAST - 1'b1;
  localparam logic [SAMPLE_W-1:0] MID      = {1'b1, {(SAMPLE_W-1){1'b0}}};

  logic [SAMPLE_W-1:0]        cnt;
  logic [SAMPLE_W-1:0]        duty;
  logic signed [SAMPLE_W-1:0] hold_q;
  logic                       hold_full;
  logic [3:0]                 volume;
  logic                       boundary;
  logic                       xfer;
  logic                       step_up;
  logic                       step_down;
  logic signed [PW-1:0]       prod;
  logic [SAMPLE_W-1:0]        duty_load;

  assign boundary       = (cnt == CNT_LAST);
  assign sample_ready   = ~hold_full;
  assign xfer           = sample_valid && sample_ready;
  assign volume_monitor = volume;

  // Signed sample times unsigned volume (zero-extended so it stays
  // non-negative), floor-divided by 16 and re-centred on midscale. The
  // offset is made signed explicitly so >>> stays an arithmetic shift.
  // The result always lies in [0, 2^SAMPLE_W-1], so truncation is exact.
  always_comb begin
    prod      = PW'(hold_q) * PW'($signed({1'b0, volume}));
    duty_load = SAMPLE_W'((prod >>> 4) + $signed(PW'(MID)));
  end

  // Frame counter and tick run regardless of en. The tick is registered off
  // the cycle before the last so it lines up with cnt == CNT_LAST.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt        <= '0;
      frame_tick <= 1'b0;
    end else begin
      cnt        <= cnt + 1'b1;
      frame_tick <= (cnt == CNT_PRE);
    end
  end

  // Holding buffer, duty load and underrun detection. While disabled the
  // buffer is flushed, duty parks at midscale and accepted samples vanish.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      hold_q    <= '0;
      hold_full <= 1'b0;
      duty      <= MID;
      underrun  <= 1'b0;
    end else if (!en) begin
      hold_full <= 1'b0;
      duty      <= MID;
      underrun  <= 1'b0;
    end else begin
      underrun <= boundary && !hold_full;
      if (boundary && hold_full) begin
        duty      <= duty_load;
        hold_full <= 1'b0;
      end else if (xfer) begin
        // Also covers a transfer in the boundary cycle with an empty buffer:
        // it is kept for the next frame, not loaded now.
        hold_q    <= $signed(sample_in);
        hold_full <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      aud_pwm <= 1'b0;
      aud_sd  <= 1'b0;
    end else begin
      aud_pwm <= en && (cnt < duty);
      aud_sd  <= en;
    end
  end

  audio_pwm_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_db_up (
    .clk    (clk),
    .resetn (resetn),
    .raw    (vol_up),
    .step   (step_up)
  );

  audio_pwm_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_db_down (
    .clk    (clk),
    .resetn (resetn),
    .raw    (vol_down),
    .step   (step_down)
  );

  // Saturating volume; simultaneous up and down steps cancel.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      volume <= 4'(VOL_RESET);
    end else if (step_up && !step_down && volume != 4'd15) begin
      volume <= volume + 1'b1;
    end else if (step_down && !step_up && volume != 4'd0) begin
      volume <= volume - 1'b1;
    end
  end
endmodule

// File: tb/tb_audio_pwm_out.sv
// ---------------------------------------------------------------------------
// tb_audio_pwm_out
//
// Directed bench for audio_pwm_out with SAMPLE_W=12 and DEBOUNCE_CYCLES=16.
// All actions happen 1 time unit after a rising edge; the bench keeps its
// own cycle count t, so the DUT frame counter equals t % 4096.
// ---------------------------------------------------------------------------
module tb_audio_pwm_out;
  localparam int FRAME = 4096;

  logic        clk = 1'b0;
  logic        resetn;
  logic        en;
  logic [11:0] sample_in;
  logic        sample_valid;
  logic        sample_ready;
  logic        vol_up;
  logic        vol_down;
  logic        aud_pwm;
  logic        aud_sd;
  logic [3:0]  volume_monitor;
  logic        frame_tick;
  logic        underrun;

  int t;
  int passed;
  int total;
  bit stream;

  always #5 clk = ~clk;

  audio_pwm_out #(
    .SAMPLE_W        (12),
    .DEBOUNCE_CYCLES (16),
    .VOL_RESET       (8)
  ) dut (
    .clk            (clk),
    .resetn         (resetn),
    .en             (en),
    .sample_in      (sample_in),
    .sample_valid   (sample_valid),
    .sample_ready   (sample_ready),
    .vol_up         (vol_up),
    .vol_down       (vol_down),
    .aud_pwm        (aud_pwm),
    .aud_sd         (aud_sd),
    .volume_monitor (volume_monitor),
    .frame_tick     (frame_tick),
    .underrun       (underrun)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
  endtask

  // One clock; in stream mode the data advances after every transfer.
  task automatic tick();
    logic xfer;
    xfer = sample_valid && sample_ready;
    @(posedge clk);
    #1;
    t++;
    if (stream && xfer) sample_in = sample_in + 12'h010;
  endtask

  task automatic goto_cnt(input int c);
    while (t % FRAME != c) tick();
  endtask

  // Runs one full frame starting at its cnt==0 cycle, counting PWM highs,
  // underrun pulses (including the one after this frame's boundary) and ticks.
  task automatic measure(output int hi, output int ur, output int ft, output int ft_pos);
    hi = 0; ur = 0; ft = 0; ft_pos = -1;
    repeat (FRAME) begin
      tick();
      hi += int'(aud_pwm);
      ur += int'(underrun);
      if (frame_tick) begin
        ft++;
        ft_pos = t % FRAME;
      end
    end
  endtask

  task automatic press(input logic up, input logic dn);
    vol_up = up; vol_down = dn;
    repeat (40) tick();
    vol_up = 1'b0; vol_down = 1'b0;
    repeat (40) tick();
  endtask

  task automatic send(input logic [11:0] d);
    sample_in = d; sample_valid = 1'b1;
    tick();
    sample_valid = 1'b0;
  endtask

  initial begin
    int hi, ur, ft, ft_pos;
    t = 0; passed = 0; total = 0; stream = 1'b0;
    resetn = 1'b1; en = 1'b0; sample_in = '0; sample_valid = 1'b0;
    vol_up = 1'b0; vol_down = 1'b0;
    #1 resetn = 1'b0;
    #1;
    check("rst_aud_pwm", aud_pwm, 0);
    check("rst_aud_sd", aud_sd, 0);
    check("rst_ready", sample_ready, 1);
    check("rst_frame_tick", frame_tick, 0);
    check("rst_underrun", underrun, 0);
    check("rst_volume", volume_monitor, 8);
    en = 1'b1;
    #1 resetn = 1'b1;

    // Idle: midscale square, one tick on cnt 4095, one underrun per frame.
    measure(hi, ur, ft, ft_pos);
    check("idle_high", hi, 2048);
    check("idle_underrun", ur, 1);
    check("idle_ticks", ft, 1);
    check("idle_tick_pos", ft_pos, 4095);
    check("idle_aud_sd", aud_sd, 1);

    // 0x7FF at volume 8 -> duty 3071 in the following frame.
    send(12'h7FF);
    check("ready_after_accept", sample_ready, 0);
    goto_cnt(4095);
    check("ready_at_boundary", sample_ready, 0);
    tick();
    check("ready_after_boundary", sample_ready, 1);
    check("no_underrun_on_load", underrun, 0);
    measure(hi, ur, ft, ft_pos);
    check("duty_7ff_vol8", hi, 3071);
    check("underrun_after_load", ur, 1);

    // Debounce: glitch ignored, held press gives exactly one step.
    vol_up = 1'b1; repeat (10) tick(); vol_up = 1'b0;
    repeat (40) tick();
    check("glitch_ignored", volume_monitor, 8);
    vol_up = 1'b1; repeat (40) tick();
    check("hold_one_step", volume_monitor, 9);
    vol_up = 1'b0; repeat (40) tick();
    check("release_no_step", volume_monitor, 9);
    for (int i = 0; i < 8; i++) press(1'b1, 1'b0);
    check("up_saturate", volume_monitor, 15);
    press(1'b1, 1'b1);
    check("both_at_15", volume_monitor, 15);

    // -2048 at volume 15 -> duty 128.
    send(12'h800);
    goto_cnt(0);
    check("no_underrun_neg", underrun, 0);
    measure(hi, ur, ft, ft_pos);
    check("duty_800_vol15", hi, 128);

    for (int i = 0; i < 17; i++) press(1'b0, 1'b1);
    check("down_saturate", volume_monitor, 0);
    press(1'b1, 1'b1);
    check("both_at_0", volume_monitor, 0);

    // Volume 0 -> midscale regardless of sample.
    send(12'h5A5);
    goto_cnt(0);
    measure(hi, ur, ft, ft_pos);
    check("duty_vol0", hi, 2048);

    press(1'b1, 1'b0);
    check("vol_to_1", volume_monitor, 1);
    goto_cnt(0);

    // Continuous valid: one sample per frame, in order (vol 1: s/16).
    stream = 1'b1;
    sample_in = 12'h100; sample_valid = 1'b1;
    measure(hi, ur, ft, ft_pos);
    check("stream_f0_high", hi, 2048);
    check("stream_f0_underrun", ur, 0);
    measure(hi, ur, ft, ft_pos);
    check("stream_f1_high", hi, 2064);
    check("stream_f1_underrun", ur, 0);
    measure(hi, ur, ft, ft_pos);
    check("stream_f2_high", hi, 2065);
    measure(hi, ur, ft, ft_pos);
    check("stream_f3_high", hi, 2066);
    sample_valid = 1'b0; stream = 1'b0;

    // Sample offered exactly in the boundary cycle lands one frame later.
    goto_cnt(4095);
    check("ready_before_bnd", sample_ready, 1);
    send(12'h7F0);
    check("bnd_underrun", underrun, 1);
    check("bnd_stored", sample_ready, 0);
    measure(hi, ur, ft, ft_pos);
    check("bnd_keep_duty", hi, 2067);
    check("bnd_no_underrun", ur, 0);
    measure(hi, ur, ft, ft_pos);
    check("bnd_sample_loaded", hi, 2175);

    // Drop en mid-frame with a full buffer.
    goto_cnt(10);
    send(12'h400);
    check("full_before_en", sample_ready, 0);
    goto_cnt(100);
    en = 1'b0;
    tick();
    check("en_off_pwm", aud_pwm, 0);
    check("en_off_sd", aud_sd, 0);
    check("en_off_ready", sample_ready, 1);
    send(12'h3FF);
    check("en_off_discard", sample_ready, 1);
    hi = 0; ur = 0;
    while (t % FRAME != 0) begin
      tick();
      hi += int'(aud_pwm);
      ur += int'(underrun);
    end
    check("en_off_pwm_quiet", hi, 0);
    check("en_off_no_underrun", ur, 0);
    en = 1'b1;
    measure(hi, ur, ft, ft_pos);
    check("en_on_midscale", hi, 2048);
    check("en_on_underrun", ur, 1);

    // Asynchronous reset mid-frame.
    send(12'h7FF);
    goto_cnt(1000);
    check("pre_reset_pwm", aud_pwm, 1);
    #2 resetn = 1'b0;
    #1;
    check("mid_rst_aud_pwm", aud_pwm, 0);
    check("mid_rst_aud_sd", aud_sd, 0);
    check("mid_rst_ready", sample_ready, 1);
    check("mid_rst_frame_tick", frame_tick, 0);
    check("mid_rst_underrun", underrun, 0);
    check("mid_rst_volume", volume_monitor, 8);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
